// File: rtl/if2_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : if2_fetch_queue
// Purpose  : Fetch-to-decode instruction queue between IF2 and ID. Buffers
//            up to DEPTH fetched packets with valid/ready handshakes on both
//            sides. A taken jump flushes every entry; a stall (stop_all or
//            pause_mem) freezes only the decode side so fetch keeps filling.
// Ports    : clk          - clock, all state updates on the rising edge
//            rst_n        - asynchronous active-low reset, clears all state
//            i_jump_en    - flush request from ID
//            i_stop_all   - global stall, blocks dequeue
//            i_pause_mem  - memory stall, blocks dequeue
//            i_in_valid   - upstream packet valid
//            i_in_data    - upstream packet
//            o_in_ready   - queue can accept a packet (not full)
//            o_out_valid  - head entry valid toward ID
//            o_out_data   - head entry payload, zero when o_out_valid=0
//            i_out_ready  - ID accepts the head entry
//            o_count      - current occupancy 0..DEPTH
//            o_full       - occupancy equals DEPTH
//            o_empty      - occupancy equals zero
// Revision : 1.0 - initial release
// ============================================================================
module if2_fetch_queue #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_jump_en,
  input  logic              i_stop_all,
  input  logic              i_pause_mem,
  input  logic              i_in_valid,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_in_ready,
  output logic              o_out_valid,
  output logic [DATA_W-1:0] o_out_data,
  input  logic              i_out_ready,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_full,
  output logic              o_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_cnt;

  logic w_stall;
  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // All status is derived from registered state only; in particular a pop
  // in the same cycle never frees room for a push (no pass-through).
  assign w_stall = i_stop_all | i_pause_mem;
  assign w_full  = (r_cnt == CNT_W'(DEPTH));
  assign w_empty = (r_cnt == '0);

  // Flush suppresses both sides of the handshake for the current cycle.
  assign w_push = i_in_valid & ~w_full & ~i_jump_en;
  assign w_pop  = ~w_empty & i_out_ready & ~w_stall & ~i_jump_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_jump_en) begin
      // Storage is left as-is: stale entries are hidden by the output mask.
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_in_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_in_ready  = ~w_full;
  assign o_out_valid = ~w_empty;
  assign o_out_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_count     = r_cnt;
  assign o_full      = w_full;
  assign o_empty     = w_empty;

endmodule
`default_nettype wire

// File: tb/tb_if2_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_if2_fetch_queue
// Purpose  : Self-checking bench for if2_fetch_queue. Three instances share
//            one stimulus bus: A (DEPTH=4, DATA_W=64), B (DEPTH=2, DATA_W=96)
//            and C (DEPTH=8, DATA_W=96). Directed scenarios use constant
//            expectations; the random scenario uses a queue-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if2_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        jump_en, stop_all, pause_mem, in_valid, out_ready;
  logic [95:0] in_data;

  logic        a_in_ready, a_out_valid, a_full, a_empty;
  logic [63:0] a_out_data;
  logic [2:0]  a_count;
  logic        b_in_ready, b_out_valid, b_full, b_empty;
  logic [95:0] b_out_data;
  logic [1:0]  b_count;
  logic        c_in_ready, c_out_valid, c_full, c_empty;
  logic [95:0] c_out_data;
  logic [3:0]  c_count;

  int vectors = 0;
  int miscompares = 0;

  if2_fetch_queue #(.DATA_W(64), .DEPTH(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .i_jump_en(jump_en), .i_stop_all(stop_all),
    .i_pause_mem(pause_mem), .i_in_valid(in_valid), .i_in_data(in_data[63:0]),
    .o_in_ready(a_in_ready), .o_out_valid(a_out_valid), .o_out_data(a_out_data),
    .i_out_ready(out_ready), .o_count(a_count), .o_full(a_full), .o_empty(a_empty));

  if2_fetch_queue #(.DATA_W(96), .DEPTH(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .i_jump_en(jump_en), .i_stop_all(stop_all),
    .i_pause_mem(pause_mem), .i_in_valid(in_valid), .i_in_data(in_data),
    .o_in_ready(b_in_ready), .o_out_valid(b_out_valid), .o_out_data(b_out_data),
    .i_out_ready(out_ready), .o_count(b_count), .o_full(b_full), .o_empty(b_empty));

  if2_fetch_queue #(.DATA_W(96), .DEPTH(8)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .i_jump_en(jump_en), .i_stop_all(stop_all),
    .i_pause_mem(pause_mem), .i_in_valid(in_valid), .i_in_data(in_data),
    .o_in_ready(c_in_ready), .o_out_valid(c_out_valid), .o_out_data(c_out_data),
    .i_out_ready(out_ready), .o_count(c_count), .o_full(c_full), .o_empty(c_empty));

  initial forever #5 clk = ~clk;

  // One clock edge, then settle 1 ns so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    jump_en = 0; stop_all = 0; pause_mem = 0;
    in_valid = 0; out_ready = 0; in_data = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 0;
    step();
    step();
    rst_n = 1;
  endtask

  function automatic logic [95:0] make_data(int i);
    logic [31:0] v;
    v = 32'(i);
    return {v * 32'h9E37_79B9, ~v, 32'h0F0F_0000 | v};
  endfunction

  task automatic test_reset();
    apply_reset();
    vectors++; if (a_out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %0b expected 0", a_out_valid); end
    vectors++; if (a_out_data !== 64'h0) begin miscompares++; $display("FAIL reset_out_data got %h expected 0", a_out_data); end
    vectors++; if (a_in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %0b expected 1", a_in_ready); end
    vectors++; if (a_empty !== 1'b1 || a_full !== 1'b0) begin miscompares++; $display("FAIL reset_flags got empty=%0b full=%0b expected empty=1 full=0", a_empty, a_full); end
    vectors++; if (a_count !== 3'd0 || b_count !== 2'd0 || c_count !== 4'd0) begin miscompares++; $display("FAIL reset_count got %0d/%0d/%0d expected 0/0/0", a_count, b_count, c_count); end
  endtask

  task automatic test_fill_drain();
    logic [63:0] exp_seq [4];
    exp_seq = '{64'h11, 64'h22, 64'h33, 64'h44};
    apply_reset();
    in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      in_data = {32'h0, exp_seq[i]};
      step();
      vectors++; if (a_count !== 3'(i + 1)) begin miscompares++; $display("FAIL fill_count[%0d] got %0d expected %0d", i, a_count, i + 1); end
    end
    vectors++; if (a_full !== 1'b1 || a_in_ready !== 1'b0) begin miscompares++; $display("FAIL fill_full got full=%0b in_ready=%0b expected full=1 in_ready=0", a_full, a_in_ready); end
    // Push into a full queue while popping: push refused, no pass-through.
    in_data = 96'h99; out_ready = 1;
    step();
    vectors++; if (a_count !== 3'd3) begin miscompares++; $display("FAIL full_push_pop_count got %0d expected 3", a_count); end
    in_valid = 0;
    for (int i = 1; i < 4; i++) begin
      vectors++; if (a_out_valid !== 1'b1 || a_out_data !== exp_seq[i]) begin miscompares++; $display("FAIL drain_data[%0d] got v=%0b %h expected v=1 %h", i, a_out_valid, a_out_data, exp_seq[i]); end
      step();
    end
    vectors++; if (a_empty !== 1'b1 || a_out_data !== 64'h0) begin miscompares++; $display("FAIL drain_empty got empty=%0b data=%h expected empty=1 data=0", a_empty, a_out_data); end
    idle_inputs();
  endtask

  task automatic test_stall();
    logic [63:0] exp_seq [4];
    exp_seq = '{64'h11, 64'h22, 64'h33, 64'h44};
    apply_reset();
    in_valid = 1; in_data = 96'h11;
    step();
    pause_mem = 1; out_ready = 1;
    for (int i = 1; i <= 3; i++) begin
      in_valid = (i < 3); in_data = {32'h0, exp_seq[i < 3 ? i : 0]};
      step();
      vectors++; if (a_out_valid !== 1'b1 || a_out_data !== 64'h11) begin miscompares++; $display("FAIL stall_hold[%0d] got v=%0b %h expected v=1 11", i, a_out_valid, a_out_data); end
      vectors++; if (a_count !== 3'(i < 3 ? i + 1 : 3)) begin miscompares++; $display("FAIL stall_count[%0d] got %0d expected %0d", i, a_count, i < 3 ? i + 1 : 3); end
    end
    pause_mem = 0; stop_all = 1; in_valid = 1; in_data = 96'h44;
    step();
    vectors++; if (a_count !== 3'd4 || a_in_ready !== 1'b0 || a_out_data !== 64'h11) begin miscompares++; $display("FAIL stop_fill got count=%0d in_ready=%0b data=%h expected 4 0 11", a_count, a_in_ready, a_out_data); end
    stop_all = 0; in_valid = 0;
    for (int i = 0; i < 4; i++) begin
      vectors++; if (a_out_data !== exp_seq[i]) begin miscompares++; $display("FAIL stall_release[%0d] got %h expected %h", i, a_out_data, exp_seq[i]); end
      step();
    end
    vectors++; if (a_empty !== 1'b1) begin miscompares++; $display("FAIL stall_release_empty got %0b expected 1", a_empty); end
    idle_inputs();
  endtask

  task automatic test_flush();
    apply_reset();
    in_valid = 1;
    for (int i = 1; i <= 3; i++) begin
      in_data = 96'(32'hA0 + i);
      step();
    end
    in_data = 96'hEE; out_ready = 1; stop_all = 1; jump_en = 1;
    step();
    vectors++; if (a_count !== 3'd0 || a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_state got count=%0d v=%0b in_ready=%0b expected 0 0 1", a_count, a_out_valid, a_in_ready); end
    vectors++; if (c_count !== 4'd0 || b_count !== 2'd0) begin miscompares++; $display("FAIL flush_sweep got %0d/%0d expected 0/0", b_count, c_count); end
    jump_en = 0; stop_all = 0; in_valid = 0;
    step();
    vectors++; if (a_out_valid !== 1'b0 || a_out_data !== 64'h0) begin miscompares++; $display("FAIL flush_discard got v=%0b %h expected v=0 0", a_out_valid, a_out_data); end
    out_ready = 0; in_valid = 1; in_data = 96'h5A;
    step();
    vectors++; if (a_out_valid !== 1'b1 || a_out_data !== 64'h5A) begin miscompares++; $display("FAIL flush_refill got v=%0b %h expected v=1 5a", a_out_valid, a_out_data); end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [95:0] d;
    apply_reset();
    in_valid = 1; out_ready = 1;
    for (int i = 1; i <= 10; i++) begin
      d = make_data(i);
      in_data = d;
      step();
      vectors++; if (a_count !== 3'd1 || a_out_data !== d[63:0]) begin miscompares++; $display("FAIL stream_a[%0d] got count=%0d %h expected 1 %h", i, a_count, a_out_data, d[63:0]); end
      vectors++; if (b_count !== 2'd1 || b_out_data !== d) begin miscompares++; $display("FAIL stream_b[%0d] got count=%0d %h expected 1 %h", i, b_count, b_out_data, d); end
      vectors++; if (c_count !== 4'd1 || c_out_data !== d) begin miscompares++; $display("FAIL stream_c[%0d] got count=%0d %h expected 1 %h", i, c_count, c_out_data, d); end
    end
    in_valid = 0;
    step();
    vectors++; if (a_empty !== 1'b1 || b_empty !== 1'b1 || c_empty !== 1'b1) begin miscompares++; $display("FAIL stream_end got %0b%0b%0b expected 111", a_empty, b_empty, c_empty); end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    apply_reset();
    in_valid = 1;
    in_data = 96'h71; step();
    in_data = 96'h72; step();
    in_valid = 0;
    vectors++; if (a_count !== 3'd2) begin miscompares++; $display("FAIL async_pre_count got %0d expected 2", a_count); end
    #2 rst_n = 0;
    #1;
    vectors++; if (a_out_valid !== 1'b0 || a_count !== 3'd0 || c_count !== 4'd0) begin miscompares++; $display("FAIL async_clear got v=%0b count=%0d/%0d expected 0 0/0", a_out_valid, a_count, c_count); end
    #2 rst_n = 1;
    in_valid = 1; in_data = 96'h55;
    step();
    vectors++; if (a_out_valid !== 1'b1 || a_out_data !== 64'h55 || a_count !== 3'd1) begin miscompares++; $display("FAIL async_first_push got v=%0b %h count=%0d expected 1 55 1", a_out_valid, a_out_data, a_count); end
    idle_inputs();
  endtask

  task automatic test_param_sweep();
    apply_reset();
    in_valid = 1;
    for (int i = 0; i < 8; i++) begin
      in_data = make_data(100 + i);
      step();
      vectors++; if (b_count !== 2'(i + 1 > 2 ? 2 : i + 1) || b_full !== (i + 1 >= 2)) begin miscompares++; $display("FAIL sweep_b_fill[%0d] got count=%0d full=%0b", i, b_count, b_full); end
      vectors++; if (c_count !== 4'(i + 1) || c_full !== (i + 1 == 8)) begin miscompares++; $display("FAIL sweep_c_fill[%0d] got count=%0d full=%0b expected %0d %0b", i, c_count, c_full, i + 1, i + 1 == 8); end
    end
    in_valid = 0; out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      vectors++; if (c_out_data !== make_data(100 + i)) begin miscompares++; $display("FAIL sweep_c_drain[%0d] got %h expected %h", i, c_out_data, make_data(100 + i)); end
      if (i < 2) begin
        vectors++; if (b_out_data !== make_data(100 + i)) begin miscompares++; $display("FAIL sweep_b_drain[%0d] got %h expected %h", i, b_out_data, make_data(100 + i)); end
      end
      step();
    end
    vectors++; if (b_empty !== 1'b1 || c_empty !== 1'b1) begin miscompares++; $display("FAIL sweep_empty got b=%0b c=%0b expected 1 1", b_empty, c_empty); end
    idle_inputs();
  endtask

  // Random traffic against a queue-level model: each instance is a bounded
  // FIFO of capacity dep[k]; occupancy decides acceptance and the head is
  // what the decode side should see.
  task automatic test_random();
    int          dep [3];
    logic [95:0] mdata [3][8];
    int          mhead [3];
    int          msize [3];
    logic [95:0] mask [3];
    logic        do_push, do_pop;
    int          act_cnt;
    logic        act_valid, act_ready;
    logic [95:0] act_data, exp_data;
    dep  = '{4, 2, 8};
    mask = '{{32'h0, {64{1'b1}}}, {96{1'b1}}, {96{1'b1}}};
    apply_reset();
    for (int k = 0; k < 3; k++) begin mhead[k] = 0; msize[k] = 0; end
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      stop_all  = ($urandom % 8) == 0;
      pause_mem = ($urandom % 8) == 0;
      jump_en   = ($urandom % 20) == 0;
      in_data   = {$urandom, $urandom, $urandom};
      for (int k = 0; k < 3; k++) begin
        if (jump_en) begin
          mhead[k] = 0; msize[k] = 0;
        end else begin
          do_push = in_valid && msize[k] < dep[k];
          do_pop  = msize[k] > 0 && out_ready && !stop_all && !pause_mem;
          if (do_pop) begin
            mhead[k] = (mhead[k] + 1) % dep[k];
            msize[k]--;
          end
          if (do_push) begin
            mdata[k][(mhead[k] + msize[k]) % dep[k]] = in_data & mask[k];
            msize[k]++;
          end
        end
      end
      step();
      for (int k = 0; k < 3; k++) begin
        case (k)
          0: begin act_cnt = int'(a_count); act_valid = a_out_valid; act_ready = a_in_ready; act_data = {32'h0, a_out_data}; end
          1: begin act_cnt = int'(b_count); act_valid = b_out_valid; act_ready = b_in_ready; act_data = b_out_data; end
          default: begin act_cnt = int'(c_count); act_valid = c_out_valid; act_ready = c_in_ready; act_data = c_out_data; end
        endcase
        exp_data = (msize[k] > 0) ? mdata[k][mhead[k]] : '0;
        vectors++; if (act_cnt > dep[k]) begin miscompares++; $display("FAIL rand_bound[%0d] inst %0d count=%0d exceeds %0d", n, k, act_cnt, dep[k]); end
        vectors++; if (act_cnt !== msize[k] || act_valid !== (msize[k] > 0) || act_ready !== (msize[k] < dep[k])) begin miscompares++; $display("FAIL rand_status[%0d] inst %0d got count=%0d v=%0b rdy=%0b expected %0d %0b %0b", n, k, act_cnt, act_valid, act_ready, msize[k], msize[k] > 0, msize[k] < dep[k]); end
        vectors++; if (act_data !== exp_data) begin miscompares++; $display("FAIL rand_data[%0d] inst %0d got %h expected %h", n, k, act_data, exp_data); end
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_n = 1;
    #1;
    test_reset();
    test_fill_drain();
    test_stall();
    test_flush();
    test_back_to_back();
    test_async_reset();
    test_param_sweep();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
